// File: rtl/mmio_requester.sv
// rtl/mmio_requester.sv - single-outstanding MMIO initiator with TID check and read timeout
// Optional statistics counters are built when MMIO_REQ_STATS_EN is defined.
module mmio_requester #(
    parameter int ADDR_W         = 16,
    parameter int TID_W          = 9,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [63:0]       cmd_data,
    output logic              req_wr_valid,
    output logic              req_rd_valid,
    output logic [ADDR_W-1:0] req_addr,
    output logic [TID_W-1:0]  req_tid,
    output logic [63:0]       req_data,
    input  logic              rsp_valid,
    input  logic [TID_W-1:0]  rsp_tid,
    input  logic [63:0]       rsp_data,
    output logic              done_valid,
    output logic [63:0]       done_data,
    output logic              done_error,
    output logic              stray_rsp,
    output logic [31:0]       stat_rd_cnt,
    output logic [31:0]       stat_wr_cnt,
    output logic [31:0]       stat_to_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        DONE
    } state_t;

    state_t           state;
    logic             is_write;
    logic [CNT_W-1:0] to_cnt;
    logic             rsp_match;

    assign rsp_match = rsp_valid && (rsp_tid == req_tid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            is_write     <= 1'b0;
            to_cnt       <= '0;
            req_wr_valid <= 1'b0;
            req_rd_valid <= 1'b0;
            req_addr     <= '0;
            req_tid      <= '0;
            req_data     <= '0;
            done_valid   <= 1'b0;
            done_data    <= '0;
            done_error   <= 1'b0;
            stray_rsp    <= 1'b0;
        end else begin
            req_wr_valid <= 1'b0;
            req_rd_valid <= 1'b0;
            done_valid   <= 1'b0;

            // Any response we are not waiting for, or with the wrong TID, is stray.
            if (rsp_valid && (state != WAIT_RSP || rsp_tid != req_tid)) begin
                stray_rsp <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        is_write     <= cmd_write;
                        req_addr     <= cmd_addr;
                        req_data     <= cmd_data;
                        req_wr_valid <= cmd_write;
                        req_rd_valid <= !cmd_write;
                        cmd_ready    <= 1'b0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (is_write) begin
                        done_valid <= 1'b1;
                        done_data  <= '0;
                        done_error <= 1'b0;
                        state      <= DONE;
                    end else begin
                        to_cnt <= '0;
                        state  <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A matching response in the last timeout cycle still wins.
                    if (rsp_match) begin
                        done_valid <= 1'b1;
                        done_data  <= rsp_data;
                        done_error <= 1'b0;
                        state      <= DONE;
                    end else if (!rsp_valid) begin
                        if (to_cnt == CNT_LAST) begin
                            done_valid <= 1'b1;
                            done_data  <= '0;
                            done_error <= 1'b1;
                            state      <= DONE;
                        end else begin
                            to_cnt <= to_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    req_tid   <= req_tid + TID_W'(1);
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef MMIO_REQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
            stat_to_cnt <= '0;
        end else if (state == DONE) begin
            if (is_write) begin
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            end else if (done_error) begin
                stat_to_cnt <= stat_to_cnt + 32'd1;
            end else begin
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
            end
        end
    end
`else
    assign stat_rd_cnt = '0;
    assign stat_wr_cnt = '0;
    assign stat_to_cnt = '0;
`endif

endmodule

// File: tb/tb_mmio_requester.sv
// tb/tb_mmio_requester.sv - directed self-checking bench for mmio_requester
module tb_mmio_requester;

    localparam int ADDR_W = 16;
    localparam int TID_W  = 9;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [63:0]       cmd_data;
    logic              req_wr_valid;
    logic              req_rd_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [TID_W-1:0]  req_tid;
    logic [63:0]       req_data;
    logic              rsp_valid;
    logic [TID_W-1:0]  rsp_tid;
    logic [63:0]       rsp_data;
    logic              done_valid;
    logic [63:0]       done_data;
    logic              done_error;
    logic              stray_rsp;
    logic [31:0]       stat_rd_cnt;
    logic [31:0]       stat_wr_cnt;
    logic [31:0]       stat_to_cnt;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mmio_requester #(
        .ADDR_W(ADDR_W),
        .TID_W(TID_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .req_wr_valid(req_wr_valid),
        .req_rd_valid(req_rd_valid),
        .req_addr(req_addr),
        .req_tid(req_tid),
        .req_data(req_data),
        .rsp_valid(rsp_valid),
        .rsp_tid(rsp_tid),
        .rsp_data(rsp_data),
        .done_valid(done_valid),
        .done_data(done_data),
        .done_error(done_error),
        .stray_rsp(stray_rsp),
        .stat_rd_cnt(stat_rd_cnt),
        .stat_wr_cnt(stat_wr_cnt),
        .stat_to_cnt(stat_to_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic offer(input logic wr, input logic [ADDR_W-1:0] a, input logic [63:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_data = '0;
        rsp_valid = 0; rsp_tid = '0; rsp_data = '0;
        step(); step();
        rst = 1'b0;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_req_tid", 64'(req_tid), 64'd0);
        check("rst_done_valid", 64'(done_valid), 64'd0);
        check("rst_stray", 64'(stray_rsp), 64'd0);
        check("rst_req_valids", 64'({req_wr_valid, req_rd_valid}), 64'd0);
        check("rst_stat_to", 64'(stat_to_cnt), 64'd0);

        // Write 0x0020: pulse next cycle, done two cycles after acceptance.
        offer(1'b1, 16'h0020, 64'hDEADBEEF_CAFEF00D);
        check("wr_pulse", 64'({req_wr_valid, req_rd_valid}), 64'b10);
        check("wr_addr", 64'(req_addr), 64'h0020);
        check("wr_data", req_data, 64'hDEADBEEF_CAFEF00D);
        check("wr_tid", 64'(req_tid), 64'd0);
        check("wr_busy", 64'(cmd_ready), 64'd0);
        check("wr_no_early_done", 64'(done_valid), 64'd0);
        step();
        check("wr_done", 64'({done_valid, done_error}), 64'b10);
        check("wr_done_data", done_data, 64'd0);
        check("wr_pulse_once", 64'(req_wr_valid), 64'd0);
        step();
        check("wr_idle", 64'({cmd_ready, done_valid}), 64'b10);
        check("wr_tid_inc", 64'(req_tid), 64'd1);

        // Read 0x0000, response three cycles after the request pulse.
        offer(1'b0, 16'h0000, 64'h0);
        check("rd_pulse", 64'({req_wr_valid, req_rd_valid}), 64'b01);
        check("rd_tid", 64'(req_tid), 64'd1);
        step(); step(); step();
        rsp_valid = 1'b1; rsp_tid = 9'd1; rsp_data = 64'h1000_0100_0000_0000;
        check("rd_wait", 64'(done_valid), 64'd0);
        step();
        rsp_valid = 1'b0;
        check("rd_done", 64'({done_valid, done_error}), 64'b10);
        check("rd_data", done_data, 64'h1000_0100_0000_0000);
        check("rd_no_stray", 64'(stray_rsp), 64'd0);
        step();
        check("rd_tid_inc", 64'(req_tid), 64'd2);

        // Read timeout: done exactly TO+1 cycles after the request pulse.
        offer(1'b0, 16'h0008, 64'h0);
        check("to_pulse", 64'(req_rd_valid), 64'd1);
        for (int i = 1; i <= TO; i++) begin
            step();
            check("to_quiet", 64'(done_valid), 64'd0);
        end
        step();
        check("to_done", 64'({done_valid, done_error}), 64'b11);
        check("to_data", done_data, 64'd0);
        step();
`ifdef MMIO_REQ_STATS_EN
        check("stat_to", 64'(stat_to_cnt), 64'd1);
        check("stat_rd", 64'(stat_rd_cnt), 64'd1);
        check("stat_wr", 64'(stat_wr_cnt), 64'd1);
`else
        check("stat_to_tied", 64'(stat_to_cnt), 64'd0);
        check("stat_rd_tied", 64'(stat_rd_cnt), 64'd0);
`endif

        // Wrong TID first (sets sticky stray), then the correct one.
        offer(1'b0, 16'h0010, 64'h0);
        check("str_tid", 64'(req_tid), 64'd3);
        step();
        rsp_valid = 1'b1; rsp_tid = 9'd4; rsp_data = 64'h1111_2222_3333_4444;
        step();
        check("str_set", 64'(stray_rsp), 64'd1);
        check("str_wait", 64'(done_valid), 64'd0);
        rsp_tid = 9'd3; rsp_data = 64'h5555_6666_7777_8888;
        step();
        rsp_valid = 1'b0;
        check("str_done", 64'({done_valid, done_error}), 64'b10);
        check("str_data", done_data, 64'h5555_6666_7777_8888);
        step();
        check("str_sticky", 64'(stray_rsp), 64'd1);

        // Matching response in the final timeout cycle beats the timeout.
        offer(1'b0, 16'h0018, 64'h0);
        for (int i = 1; i < TO; i++) step();
        step();
        rsp_valid = 1'b1; rsp_tid = 9'd4; rsp_data = 64'h0123_4567_89AB_CDEF;
        check("race_wait", 64'(done_valid), 64'd0);
        step();
        rsp_valid = 1'b0;
        check("race_done", 64'({done_valid, done_error}), 64'b10);
        check("race_data", done_data, 64'h0123_4567_89AB_CDEF);
        step();

        // Reset clears TID and sticky stray, then 513 writes wrap the TID.
        rst = 1'b1; step(); rst = 1'b0;
        check("rst2_tid", 64'(req_tid), 64'd0);
        check("rst2_stray", 64'(stray_rsp), 64'd0);
        for (int i = 0; i < 512; i++) begin
            offer(1'b1, 16'(i), 64'(i));
            check("wrap_tid", 64'(req_tid), 64'(i));
            step(); step();
        end
        offer(1'b1, 16'h0004, 64'h0);
        check("wrap_zero", 64'(req_tid), 64'd0);
        step(); step();

        // Reset while waiting: no completion, late response is stray.
        offer(1'b0, 16'h0000, 64'h0);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        check("mid_rst_tid", 64'(req_tid), 64'd0);
        check("mid_rst_done", 64'(done_valid), 64'd0);
        rsp_valid = 1'b1; rsp_tid = 9'd1; rsp_data = 64'hFFFF;
        step();
        rsp_valid = 1'b0;
        check("late_no_done", 64'(done_valid), 64'd0);
        check("late_stray", 64'(stray_rsp), 64'd1);
        step();
        check("late_still_idle", 64'({cmd_ready, done_valid}), 64'b10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
